// File: rtl/pipeline_vnr1.sv
// Multi-stage valid/ready pipeline with bubble collapsing and per-beat sequence tags; optional input skid via PIPELINE_VNR1_SKID_EN.
// Latency: DEPTH cycles from acceptance to o_valid when unstalled (an empty skid is bypassed).
// Backpressure: ready ripples back from i_ready through empty stages; with the skid, o_ready is registered (aside from i_clear).
module pipeline_vnr1 #(
    parameter int VALUE_BITS = 8,
    parameter int STATE_BITS = 8,
    parameter int DEPTH      = 3
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  i_clear,
    input  logic [VALUE_BITS-1:0] i_value,
    input  logic                  i_valid,
    output logic                  o_ready,
    output logic [VALUE_BITS-1:0] o_value,
    output logic [STATE_BITS-1:0] o_state,
    output logic                  o_valid,
    input  logic                  i_ready
);

    logic [DEPTH-1:0]      stg_vld;
    logic [VALUE_BITS-1:0] stg_dat [DEPTH];
    logic [STATE_BITS-1:0] stg_tag [DEPTH];
    logic [DEPTH-1:0]      stg_rdy;
    logic                  rdy_acc;

    logic [STATE_BITS-1:0] r_count;
    logic                  accept;
    logic                  in_vld;
    logic [VALUE_BITS-1:0] in_dat;
    logic [STATE_BITS-1:0] in_tag;

    // stg_rdy[k] is high when any stage from k onward is empty or the consumer is ready
    always_comb begin
        rdy_acc = i_ready;
        stg_rdy = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            rdy_acc    = ~stg_vld[k] | rdy_acc;
            stg_rdy[k] = rdy_acc;
        end
    end

    assign accept = i_valid & o_ready;

`ifdef PIPELINE_VNR1_SKID_EN
    logic                  skid_vld;
    logic [VALUE_BITS-1:0] skid_dat;
    logic [STATE_BITS-1:0] skid_tag;

    assign o_ready = ~skid_vld & ~i_clear;
    assign in_vld  = skid_vld | accept;
    assign in_dat  = skid_vld ? skid_dat : i_value;
    assign in_tag  = skid_vld ? skid_tag : r_count;

    // Skid only fills when s0 cannot take the beat; it drains ahead of any new input
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            skid_vld <= 1'b0;
            skid_dat <= '0;
            skid_tag <= '0;
        end else if (i_clear) begin
            skid_vld <= 1'b0;
        end else if (skid_vld) begin
            if (stg_rdy[0]) begin
                skid_vld <= 1'b0;
            end
        end else if (accept && !stg_rdy[0]) begin
            skid_vld <= 1'b1;
            skid_dat <= i_value;
            skid_tag <= r_count;
        end
    end
`else
    assign o_ready = stg_rdy[0] & ~i_clear;
    assign in_vld  = accept;
    assign in_dat  = i_value;
    assign in_tag  = r_count;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (accept) begin
            r_count <= r_count + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stg_vld <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                stg_dat[k] <= '0;
                stg_tag[k] <= '0;
            end
        end else if (i_clear) begin
            stg_vld <= '0;
        end else begin
            if (stg_rdy[0]) begin
                stg_vld[0] <= in_vld;
                if (in_vld) begin
                    stg_dat[0] <= in_dat;
                    stg_tag[0] <= in_tag;
                end
            end
            for (int k = 1; k < DEPTH; k++) begin
                if (stg_rdy[k]) begin
                    stg_vld[k] <= stg_vld[k-1];
                    if (stg_vld[k-1]) begin
                        stg_dat[k] <= stg_dat[k-1];
                        stg_tag[k] <= stg_tag[k-1];
                    end
                end
            end
        end
    end

    assign o_valid = stg_vld[DEPTH-1];
    assign o_value = stg_dat[DEPTH-1];
    assign o_state = stg_tag[DEPTH-1];

endmodule

// File: tb/tb_pipeline_vnr1.sv
// Bench for pipeline_vnr1: directed steps plus random traffic against an in-order queue model with a free-running tag count.
module tb_pipeline_vnr1;

    localparam int VB    = 8;
    localparam int SB    = 8;
    localparam int DEPTH = 3;
`ifdef PIPELINE_VNR1_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif
    localparam int CAP = DEPTH + (SKID ? 1 : 0);

    logic          clock;
    logic          reset_n;
    logic          i_clear;
    logic [VB-1:0] i_value;
    logic          i_valid;
    logic          o_ready;
    logic [VB-1:0] o_value;
    logic [SB-1:0] o_state;
    logic          o_valid;
    logic          i_ready;

    pipeline_vnr1 #(.VALUE_BITS(VB), .STATE_BITS(SB), .DEPTH(DEPTH)) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .i_clear(i_clear),
        .i_value(i_value),
        .i_valid(i_valid),
        .o_ready(o_ready),
        .o_value(o_value),
        .o_state(o_state),
        .o_valid(o_valid),
        .i_ready(i_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic [VB-1:0] v;
        logic [SB-1:0] t;
    } beat_t;

    beat_t q[$];
    int    cnt;
    int    vectors;
    int    miscompares;
    logic  last_acc;
    int    accepts;
    int    seed;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Ready seen by the producer: free room somewhere, or (no skid) the consumer takes a beat this cycle
    function automatic logic exp_rdy();
        if (i_clear) return 1'b0;
        if (SKID) return q.size() <= DEPTH;
        return (q.size() < DEPTH) || i_ready;
    endfunction

    task automatic cycle(input int vld_exp);
        logic          acc;
        logic          leave;
        logic          clr;
        logic          r0;
        logic [VB-1:0] val;
        beat_t         h;
        @(negedge clock);
        chk("o_ready", o_ready, exp_rdy());
        if (vld_exp >= 0) chk("o_valid_timing", o_valid, vld_exp);
        if (q.size() == 0) begin
            chk("o_valid_when_empty", o_valid, 0);
        end else if (o_valid) begin
            h = q[0];
            chk("o_value", o_value, h.v);
            chk("o_state", o_state, h.t);
        end
`ifdef PIPELINE_VNR1_SKID_EN
        r0 = o_ready;
        i_ready = ~i_ready;
        #1;
        chk("o_ready_indep_of_i_ready", o_ready, r0);
        i_ready = ~i_ready;
        #1;
`else
        r0 = 1'b0;
`endif
        acc   = i_valid & o_ready;
        leave = o_valid & i_ready;
        clr   = i_clear;
        val   = i_value;
        @(posedge clock);
        #1;
        last_acc = acc;
        if (clr) begin
            q.delete();
            cnt = 0;
        end else begin
            if (leave && q.size() > 0) void'(q.pop_front());
            if (acc) begin
                h.v = val;
                h.t = SB'(cnt % (1 << SB));
                q.push_back(h);
                cnt++;
            end
        end
    endtask

    task automatic drain(input string tag);
        i_valid = 1'b0;
        i_ready = 1'b1;
        for (int k = 0; k < 60 && q.size() > 0; k++) cycle(-1);
        chk(tag, q.size(), 0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        cnt         = 0;
        last_acc    = 1'b0;
        seed        = $urandom(1234);
        reset_n     = 1'b0;
        i_clear     = 1'b0;
        i_value     = '0;
        i_valid     = 1'b0;
        i_ready     = 1'b0;

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        chk("rst_o_valid", o_valid, 0);
        chk("rst_o_value", o_value, 0);
        chk("rst_o_state", o_state, 0);
        #2;
        reset_n = 1'b1;
        #1;
        chk("rst_o_ready", o_ready, 1);
        @(posedge clock);
        #1;

        // Streaming 0x10..0x17 with exact latency and no gaps
        i_ready = 1'b1;
        for (int j = 0; j < DEPTH + 10; j++) begin
            i_valid = (j < 8);
            i_value = VB'(8'h10 + j);
            cycle((j >= DEPTH && j < DEPTH + 8) ? 1 : 0);
        end
        drain("stream_drain");

        // Backpressure: count accepts until o_ready falls
        i_ready = 1'b0;
        i_valid = 1'b1;
        accepts = 0;
        for (int j = 0; j < CAP + 4; j++) begin
            i_value = VB'($urandom);
            cycle(-1);
            if (last_acc) accepts++;
        end
        chk("bp_accepts", accepts, CAP);
        chk("bp_o_ready_low", o_ready, 0);
        i_ready = 1'b1;
        for (int j = 0; j < 12; j++) begin
            i_value = VB'($urandom);
            cycle(1);
        end
        drain("bp_drain");

        // Clear with two beats in flight
        i_valid = 1'b1;
        for (int j = 0; j < 2; j++) begin
            i_value = VB'(8'h60 + j);
            cycle(-1);
        end
        i_clear = 1'b1;
        i_value = 8'h77;
        cycle(-1);
        i_clear = 1'b0;
        i_valid = 1'b0;
        for (int j = 0; j < DEPTH + 3; j++) cycle(0);
        i_valid = 1'b1;
        i_value = 8'h5a;
        cycle(-1);
        i_valid = 1'b0;
        for (int j = 0; j < DEPTH + 2; j++) cycle(-1);
        drain("clear_drain");

        // Bubbles: alternating valid, random ready
        for (int j = 0; j < 200; j++) begin
            i_valid = (j % 2 == 0);
            i_ready = 1'($urandom_range(0, 1));
            i_value = VB'($urandom);
            cycle(-1);
        end
        drain("bubble_drain");

        // Dense random traffic, long enough for the tag to wrap
        for (int j = 0; j < 700; j++) begin
            i_valid = ($urandom_range(0, 3) != 0);
            i_ready = ($urandom_range(0, 3) != 0);
            i_value = VB'($urandom);
            cycle(-1);
        end
        chk("wrap_reached", (cnt > (1 << SB)) ? 1 : 0, 1);
        drain("random_drain");

        // Asynchronous reset mid-stream
        i_ready = 1'b0;
        i_valid = 1'b1;
        for (int j = 0; j < DEPTH + 2; j++) begin
            i_value = 8'ha5;
            cycle(-1);
        end
        chk("pre_reset_o_valid", o_valid, 1);
        reset_n = 1'b0;
        #1;
        chk("midrst_o_valid", o_valid, 0);
        chk("midrst_o_value", o_value, 0);
        chk("midrst_o_state", o_state, 0);
        q.delete();
        cnt = 0;
        i_valid = 1'b0;
        @(posedge clock);
        #2;
        reset_n = 1'b1;
        #1;
        chk("postrst_o_ready", o_ready, 1);
        i_ready = 1'b1;
        i_valid = 1'b1;
        for (int j = 0; j < 4; j++) begin
            i_value = VB'(8'hc0 + j);
            cycle(-1);
        end
        drain("final_drain");
        chk("final_o_valid", o_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

endmodule
